// File: rtl/shifter_operand_unit.sv
// ARM operand-2 shifter feeding the ALU: decodes the operand source on the accepting edge,
// then rotates or shifts it one bit per clock until the requested amount has been applied.
module shifter_operand_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [1:0]       shiftType,
    input  logic [4:0]       shiftImm,
    input  logic [3:0]       rotateImm,
    input  logic [7:0]       imm8,
    input  logic [WIDTH-1:0] rm,
    input  logic [7:0]       rs,
    input  logic             carryIn,
    output logic [WIDTH-1:0] shifterOut,
    output logic             shifterCarry,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [1:0] TypeLsl = 2'b00;
    localparam logic [1:0] TypeLsr = 2'b01;
    localparam logic [1:0] TypeAsr = 2'b10;
    localparam logic [1:0] TypeRor = 2'b11;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         type_q, type_d;
    logic               rrx_q, rrx_d;

    logic [WIDTH-1:0]   ld_work;
    logic               ld_carry;
    logic [CNT_W-1:0]   ld_cnt;
    logic [1:0]         ld_type;
    logic               ld_rrx;
    logic [WIDTH-1:0]   st_work;
    logic               st_carry;

    // Operand decode: source value, starting carry, step count and effective step kind.
    always_comb begin
        ld_work  = rm;
        ld_carry = carryIn;
        ld_cnt   = '0;
        ld_type  = shiftType;
        ld_rrx   = 1'b0;
        unique case (mode)
            2'b00: begin
                ld_work = {{(WIDTH-8){1'b0}}, imm8};
                ld_type = TypeRor;
                ld_cnt  = CNT_W'({rotateImm, 1'b0});
            end
            2'b01: begin
                unique case (shiftType)
                    TypeLsl: ld_cnt = CNT_W'(shiftImm);
                    TypeLsr, TypeAsr: ld_cnt = (shiftImm == 5'd0) ? CNT_W'(32) : CNT_W'(shiftImm);
                    default: begin
                        if (shiftImm == 5'd0) begin
                            ld_cnt = CNT_W'(1);
                            ld_rrx = 1'b1;
                        end else begin
                            ld_cnt = CNT_W'(shiftImm);
                        end
                    end
                endcase
            end
            2'b10: begin
                if (rs != 8'd0) begin
                    unique case (shiftType)
                        TypeAsr: ld_cnt = (rs >= 8'd32) ? CNT_W'(32) : CNT_W'(rs);
                        TypeRor: begin
                            ld_cnt = CNT_W'(rs[4:0]);
                            if (rs[4:0] == 5'd0) ld_carry = rm[WIDTH-1];
                        end
                        default: ld_cnt = (rs >= 8'd33) ? CNT_W'(33) : CNT_W'(rs);
                    endcase
                end
            end
            default: ;
        endcase
    end

    // One-bit step; RRX rotates the held carry in instead of bit 0.
    always_comb begin
        st_work  = work_q;
        st_carry = work_q[0];
        unique case (type_q)
            TypeLsl: begin
                st_carry = work_q[WIDTH-1];
                st_work  = {work_q[WIDTH-2:0], 1'b0};
            end
            TypeLsr: st_work = {1'b0, work_q[WIDTH-1:1]};
            TypeAsr: st_work = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: st_work = {(rrx_q ? carry_q : work_q[0]), work_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        rrx_d   = rrx_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    work_d  = ld_work;
                    carry_d = ld_carry;
                    cnt_d   = ld_cnt;
                    type_d  = ld_type;
                    rrx_d   = ld_rrx;
                    state_d = (ld_cnt == '0) ? StDone : StShift;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                work_d  = st_work;
                carry_d = st_carry;
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            type_q  <= 2'b00;
            rrx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            rrx_q   <= rrx_d;
        end
    end

    assign shifterOut   = work_q;
    assign shifterCarry = carry_q;
    assign busy         = (state_q == StShift);
    assign done         = (state_q == StDone);

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Scoreboard bench for shifter_operand_unit: directed operations push expected results,
// a negedge monitor pops and checks value, carry, latency and busy duration on each done.
module tb_shifter_operand_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  shiftType;
    logic [4:0]  shiftImm;
    logic [3:0]  rotateImm;
    logic [7:0]  imm8;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        carryIn;
    logic [31:0] shifterOut;
    logic        shifterCarry;
    logic        busy;
    logic        done;

    shifter_operand_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .start        (start),
        .mode         (mode),
        .shiftType    (shiftType),
        .shiftImm     (shiftImm),
        .rotateImm    (rotateImm),
        .imm8         (imm8),
        .rm           (rm),
        .rs           (rs),
        .carryIn      (carryIn),
        .shifterOut   (shifterOut),
        .shifterCarry (shifterCarry),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        c;
        int          edges;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!resetN) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    e = sb.pop_front();
                    check({e.name, " out"}, shifterOut, e.out);
                    check({e.name, " carry"}, {31'b0, shifterCarry}, {31'b0, e.c});
                    check({e.name, " latency"}, cyc - e.acc + 1, e.edges);
                    check({e.name, " busy_cycles"}, busy_cnt, e.edges - 1);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] m, input logic [1:0] t,
                         input logic [4:0] si, input logic [3:0] ri, input logic [7:0] i8,
                         input logic [31:0] r, input logic [7:0] s, input logic ci,
                         input logic [31:0] eo, input logic ec, input int n);
        exp_t e;
        @(negedge clk);
        mode = m; shiftType = t; shiftImm = si; rotateImm = ri; imm8 = i8;
        rm = r; rs = s; carryIn = ci; start = 1'b1;
        e.name = name; e.out = eo; e.c = ec; e.edges = n + 1; e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        // Inputs after the accepting edge must not matter.
        rm = ~rm; rs = ~rs; imm8 = ~imm8; shiftImm = ~shiftImm; rotateImm = ~rotateImm;
        carryIn = ~carryIn; shiftType = ~shiftType;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no done expected done within 100 cycles", name);
            sb.delete();
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] m, input logic [1:0] t,
                          input logic [4:0] si, input logic [3:0] ri, input logic [7:0] i8,
                          input logic [31:0] r, input logic [7:0] s, input logic ci,
                          input logic [31:0] eo, input logic ec, input int n);
        issue(name, m, t, si, ri, i8, r, s, ci, eo, ec, n);
        wait_drain(name);
    endtask

    initial begin
        resetN = 1'b0; start = 1'b0; mode = 2'b00; shiftType = 2'b00; shiftImm = 5'd0;
        rotateImm = 4'd0; imm8 = 8'd0; rm = 32'd0; rs = 8'd0; carryIn = 1'b0;
        #3;
        check("reset out", shifterOut, 32'h0);
        check("reset carry", {31'b0, shifterCarry}, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        //      name          mode   type   sImm   rot   imm8   rm            rs     cin   out           C     N
        run_op("imm_ror8",    2'b00, 2'b00, 5'd0,  4'd4, 8'hFF, 32'h0,        8'd0,  1'b0, 32'hFF000000, 1'b1, 8);
        run_op("imm_rot0",    2'b00, 2'b00, 5'd0,  4'd0, 8'h5A, 32'h0,        8'd0,  1'b1, 32'h0000005A, 1'b1, 0);
        run_op("lsr_imm32",   2'b01, 2'b01, 5'd0,  4'd0, 8'h0,  32'h80000001, 8'd0,  1'b0, 32'h0,        1'b1, 32);
        run_op("rrx",         2'b01, 2'b11, 5'd0,  4'd0, 8'h0,  32'h00000003, 8'd0,  1'b1, 32'h80000001, 1'b1, 1);
        run_op("lsl_imm0",    2'b01, 2'b00, 5'd0,  4'd0, 8'h0,  32'h12345678, 8'd0,  1'b0, 32'h12345678, 1'b0, 0);
        run_op("lsl_imm4",    2'b01, 2'b00, 5'd4,  4'd0, 8'h0,  32'hF0000001, 8'd0,  1'b0, 32'h00000010, 1'b1, 4);
        run_op("asr_imm32",   2'b01, 2'b10, 5'd0,  4'd0, 8'h0,  32'h40000000, 8'd0,  1'b1, 32'h0,        1'b0, 32);
        run_op("ror_imm4",    2'b01, 2'b11, 5'd4,  4'd0, 8'h0,  32'h0000000F, 8'd0,  1'b0, 32'hF0000000, 1'b1, 4);
        run_op("lsl_reg40",   2'b10, 2'b00, 5'd0,  4'd0, 8'h0,  32'hFFFFFFFF, 8'd40, 1'b1, 32'h0,        1'b0, 33);
        run_op("lsl_reg0",    2'b10, 2'b00, 5'd0,  4'd0, 8'h0,  32'hFFFFFFFF, 8'd0,  1'b1, 32'hFFFFFFFF, 1'b1, 0);
        run_op("ror_reg32",   2'b10, 2'b11, 5'd0,  4'd0, 8'h0,  32'h80000000, 8'd32, 1'b0, 32'h80000000, 1'b1, 0);
        run_op("lsr_reg32",   2'b10, 2'b01, 5'd0,  4'd0, 8'h0,  32'h80000000, 8'd32, 1'b0, 32'h0,        1'b1, 32);
        run_op("asr_reg200",  2'b10, 2'b10, 5'd0,  4'd0, 8'h0,  32'h7FFFFFFF, 8'd200, 1'b1, 32'h0,       1'b0, 32);
        run_op("ror_reg36",   2'b10, 2'b11, 5'd0,  4'd0, 8'h0,  32'h12345678, 8'd36, 1'b0, 32'h81234567, 1'b1, 4);
        run_op("illegal",     2'b11, 2'b01, 5'd3,  4'd0, 8'h0,  32'hDEADBEEF, 8'd5,  1'b1, 32'hDEADBEEF, 1'b1, 0);

        // start pulsed mid-shift with different operands must be ignored
        issue("asr_reg8",     2'b10, 2'b10, 5'd0,  4'd0, 8'h0,  32'h80000080, 8'd8,  1'b0, 32'hFF800000, 1'b1, 8);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("asr_reg8");

        // asynchronous reset mid-shift drops the operation
        issue("dropped",      2'b01, 2'b01, 5'd0,  4'd0, 8'h0,  32'h80000001, 8'd0,  1'b0, 32'h0,        1'b1, 32);
        repeat (5) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("midreset out", shifterOut, 32'h0);
        check("midreset busy", {31'b0, busy}, 32'h0);
        check("midreset done", {31'b0, done}, 32'h0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        run_op("after_reset", 2'b00, 2'b00, 5'd0,  4'd4, 8'hFF, 32'h0,        8'd0,  1'b0, 32'hFF000000, 1'b1, 8);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
